// File: rtl/procyon_lsu_sq_fwd_pkg.sv
// Shared types and helpers for the forwarding store queue.
package procyon_lsu_sq_fwd_pkg;

  localparam int unsigned BYTE_WIDTH = 8;

  function automatic int unsigned lane_count(input int unsigned data_width);
    return data_width / BYTE_WIDTH;
  endfunction

  typedef enum logic [1:0] {
    LOOKUP_MISS     = 2'b00,
    LOOKUP_HIT      = 2'b01,
    LOOKUP_CONFLICT = 2'b10
  } lookup_result_t;

endpackage

// File: rtl/procyon_lsu_sq_fwd_pick.sv
// Circular youngest-first select: scans downward from i_start and returns the
// first set bit of i_match as a one-hot vector.
module procyon_sq_fwd_pick #(
  parameter int OPTN_SQ_DEPTH = 8
) (
  input  logic [OPTN_SQ_DEPTH-1:0]         i_match,
  input  logic [$clog2(OPTN_SQ_DEPTH)-1:0] i_start,
  output logic [OPTN_SQ_DEPTH-1:0]         o_onehot,
  output logic                             o_found
);

  localparam int IDX_W = $clog2(OPTN_SQ_DEPTH);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_onehot = '0;
    o_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < OPTN_SQ_DEPTH; k++) begin
      w_idx = i_start - IDX_W'(k);
      if (!o_found && i_match[w_idx]) begin
        o_onehot[w_idx] = 1'b1;
        o_found         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/procyon_lsu_sq_fwd.sv
// Store queue holding speculative stores in program order, committing on ROB
// retirement, draining to the D$ and forwarding to younger loads.
module procyon_lsu_sq_fwd
  import procyon_lsu_sq_fwd_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ADDR_WIDTH    = 32,
  parameter int OPTN_SQ_DEPTH      = 8,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  localparam int BL           = lane_count(OPTN_DATA_WIDTH),
  localparam int SQ_IDX_WIDTH = $clog2(OPTN_SQ_DEPTH)
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          i_flush,
  input  logic                          i_alloc_en,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_alloc_tag,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_alloc_addr,
  input  logic [OPTN_DATA_WIDTH-1:0]    i_alloc_data,
  input  logic [BL-1:0]                 i_alloc_byte_mask,
  output logic                          o_full,
  output logic [SQ_IDX_WIDTH:0]         o_tail,
  input  logic                          i_rob_retire_en,
  input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_rob_retire_tag,
  output logic                          o_rob_retire_ack,
  output logic                          o_drain_en,
  output logic [OPTN_ADDR_WIDTH-1:0]    o_drain_addr,
  output logic [OPTN_DATA_WIDTH-1:0]    o_drain_data,
  output logic [BL-1:0]                 o_drain_byte_mask,
  input  logic                          i_drain_ack,
  input  logic                          i_lookup_en,
  input  logic [OPTN_ADDR_WIDTH-1:0]    i_lookup_addr,
  input  logic [BL-1:0]                 i_lookup_byte_mask,
  input  logic [SQ_IDX_WIDTH:0]         i_lookup_sq_tail,
  output logic                          o_lookup_valid,
  output logic                          o_lookup_hit,
  output logic                          o_lookup_conflict,
  output logic [OPTN_DATA_WIDTH-1:0]    o_lookup_data
);

  localparam int LANE_BITS = $clog2(BL);

  logic [SQ_IDX_WIDTH:0]         r_head, r_commit, r_tail;
  logic [OPTN_ROB_IDX_WIDTH-1:0] r_tag  [OPTN_SQ_DEPTH];
  logic [OPTN_ADDR_WIDTH-1:0]    r_addr [OPTN_SQ_DEPTH];
  logic [OPTN_DATA_WIDTH-1:0]    r_data [OPTN_SQ_DEPTH];
  logic [BL-1:0]                 r_mask [OPTN_SQ_DEPTH];

  logic                          r_ack;
  logic                          r_lk_valid;
  lookup_result_t                r_lk_result;
  logic [OPTN_DATA_WIDTH-1:0]    r_lk_data;

  logic [SQ_IDX_WIDTH-1:0] w_head_idx, w_commit_idx, w_tail_idx, w_pick_start;
  logic                    w_full, w_alloc, w_commit, w_drain_en, w_drain, w_lk_fire;
  logic [SQ_IDX_WIDTH:0]   w_commit_next, w_count;
  logic [SQ_IDX_WIDTH-1:0] w_off;
  logic [OPTN_SQ_DEPTH-1:0] w_match, w_onehot;
  logic                    w_found;
  logic [BL-1:0]           w_sel_mask;
  logic [OPTN_DATA_WIDTH-1:0] w_sel_data;
  lookup_result_t          w_result;

  assign w_head_idx   = r_head[SQ_IDX_WIDTH-1:0];
  assign w_commit_idx = r_commit[SQ_IDX_WIDTH-1:0];
  assign w_tail_idx   = r_tail[SQ_IDX_WIDTH-1:0];

  assign w_full        = (w_head_idx == w_tail_idx) && (r_head[SQ_IDX_WIDTH] != r_tail[SQ_IDX_WIDTH]);
  assign w_alloc       = i_alloc_en && !w_full && !i_flush;
  assign w_commit      = i_rob_retire_en && (r_commit != r_tail) && (r_tag[w_commit_idx] == i_rob_retire_tag);
  assign w_commit_next = w_commit ? r_commit + 1'b1 : r_commit;
  assign w_drain_en    = (r_head != r_commit);
  assign w_drain       = i_drain_ack && w_drain_en;
  assign w_lk_fire     = i_lookup_en && !i_flush;

  // Flush rolls the tail back onto the commit pointer, keeping any commit made this cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_head   <= '0;
      r_commit <= '0;
      r_tail   <= '0;
      r_ack    <= 1'b0;
    end else begin
      if (w_drain) r_head <= r_head + 1'b1;
      r_commit <= w_commit_next;
      if (i_flush)      r_tail <= w_commit_next;
      else if (w_alloc) r_tail <= r_tail + 1'b1;
      r_ack <= w_commit;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < OPTN_SQ_DEPTH; i++) begin
        r_tag[i]  <= '0;
        r_addr[i] <= '0;
        r_data[i] <= '0;
        r_mask[i] <= '0;
      end
    end else if (w_alloc) begin
      r_tag[w_tail_idx]  <= i_alloc_tag;
      r_addr[w_tail_idx] <= i_alloc_addr;
      r_data[w_tail_idx] <= i_alloc_data;
      r_mask[w_tail_idx] <= i_alloc_byte_mask;
    end
  end

  // A snapshot older than head (its stores already drained) yields an empty search window.
  assign w_count      = i_lookup_sq_tail - r_head;
  assign w_pick_start = i_lookup_sq_tail[SQ_IDX_WIDTH-1:0] - 1'b1;

  always_comb begin
    w_match = '0;
    w_off   = '0;
    for (int i = 0; i < OPTN_SQ_DEPTH; i++) begin
      w_off = SQ_IDX_WIDTH'(i) - w_head_idx;
      w_match[i] = (w_count <= (SQ_IDX_WIDTH+1)'(OPTN_SQ_DEPTH)) &&
                   ({1'b0, w_off} < w_count) &&
                   ((r_addr[i] >> LANE_BITS) == (i_lookup_addr >> LANE_BITS)) &&
                   (|(r_mask[i] & i_lookup_byte_mask));
    end
  end

  procyon_sq_fwd_pick #(
    .OPTN_SQ_DEPTH(OPTN_SQ_DEPTH)
  ) u_pick (
    .i_match  (w_match),
    .i_start  (w_pick_start),
    .o_onehot (w_onehot),
    .o_found  (w_found)
  );

  always_comb begin
    w_sel_mask = '0;
    w_sel_data = '0;
    for (int i = 0; i < OPTN_SQ_DEPTH; i++) begin
      w_sel_mask = w_sel_mask | (r_mask[i] & {BL{w_onehot[i]}});
      w_sel_data = w_sel_data | (r_data[i] & {OPTN_DATA_WIDTH{w_onehot[i]}});
    end
    if (!w_found)
      w_result = LOOKUP_MISS;
    else if ((w_sel_mask & i_lookup_byte_mask) == i_lookup_byte_mask)
      w_result = LOOKUP_HIT;
    else
      w_result = LOOKUP_CONFLICT;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_lk_valid  <= 1'b0;
      r_lk_result <= LOOKUP_MISS;
      r_lk_data   <= '0;
    end else begin
      r_lk_valid  <= w_lk_fire;
      r_lk_result <= w_lk_fire ? w_result : LOOKUP_MISS;
      r_lk_data   <= (w_lk_fire && (w_result == LOOKUP_HIT)) ? w_sel_data : '0;
    end
  end

  assign o_full            = w_full;
  assign o_tail            = r_tail;
  assign o_rob_retire_ack  = r_ack;
  assign o_drain_en        = w_drain_en;
  assign o_drain_addr      = r_addr[w_head_idx];
  assign o_drain_data      = r_data[w_head_idx];
  assign o_drain_byte_mask = r_mask[w_head_idx];
  assign o_lookup_valid    = r_lk_valid;
  assign o_lookup_hit      = (r_lk_result == LOOKUP_HIT);
  assign o_lookup_conflict = (r_lk_result == LOOKUP_CONFLICT);
  assign o_lookup_data     = r_lk_data;

endmodule

// File: tb/tb_procyon_lsu_sq_fwd.sv
// Self-checking bench for procyon_lsu_sq_fwd: directed scenarios plus a
// randomized run against a sequence-numbered reference model.
module tb_procyon_lsu_sq_fwd;

  localparam int DW = 32, AW = 32, DEPTH = 8, RW = 5, BL = 4, IW = 3;

  logic clk = 1'b0;
  logic n_rst;
  logic i_flush, i_alloc_en, i_rob_retire_en, i_drain_ack, i_lookup_en;
  logic [RW-1:0] i_alloc_tag, i_rob_retire_tag;
  logic [AW-1:0] i_alloc_addr, i_lookup_addr;
  logic [DW-1:0] i_alloc_data;
  logic [BL-1:0] i_alloc_byte_mask, i_lookup_byte_mask;
  logic [IW:0]   i_lookup_sq_tail;
  logic o_full, o_rob_retire_ack, o_drain_en, o_lookup_valid, o_lookup_hit, o_lookup_conflict;
  logic [IW:0]   o_tail;
  logic [AW-1:0] o_drain_addr;
  logic [DW-1:0] o_drain_data, o_lookup_data;
  logic [BL-1:0] o_drain_byte_mask;

  always #5 clk = ~clk;

  procyon_lsu_sq_fwd dut (
    .clk(clk), .n_rst(n_rst), .i_flush(i_flush),
    .i_alloc_en(i_alloc_en), .i_alloc_tag(i_alloc_tag), .i_alloc_addr(i_alloc_addr),
    .i_alloc_data(i_alloc_data), .i_alloc_byte_mask(i_alloc_byte_mask),
    .o_full(o_full), .o_tail(o_tail),
    .i_rob_retire_en(i_rob_retire_en), .i_rob_retire_tag(i_rob_retire_tag),
    .o_rob_retire_ack(o_rob_retire_ack),
    .o_drain_en(o_drain_en), .o_drain_addr(o_drain_addr), .o_drain_data(o_drain_data),
    .o_drain_byte_mask(o_drain_byte_mask), .i_drain_ack(i_drain_ack),
    .i_lookup_en(i_lookup_en), .i_lookup_addr(i_lookup_addr),
    .i_lookup_byte_mask(i_lookup_byte_mask), .i_lookup_sq_tail(i_lookup_sq_tail),
    .o_lookup_valid(o_lookup_valid), .o_lookup_hit(o_lookup_hit),
    .o_lookup_conflict(o_lookup_conflict), .o_lookup_data(o_lookup_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: stores numbered by absolute program-order sequence.
  int mHead, mCommit, mTail, lSnap;
  logic [AW-1:0] mAddr [256];
  logic [DW-1:0] mData [256];
  logic [BL-1:0] mMask [256];
  logic [RW-1:0] mTag  [256];
  logic expValid, expHit, expConf, expAck;
  logic [DW-1:0] expData;

  task automatic clearInputs();
    i_flush = 0; i_alloc_en = 0; i_alloc_tag = '0; i_alloc_addr = '0; i_alloc_data = '0;
    i_alloc_byte_mask = '0; i_rob_retire_en = 0; i_rob_retire_tag = '0; i_drain_ack = 0;
    i_lookup_en = 0; i_lookup_addr = '0; i_lookup_byte_mask = '0; lSnap = mTail;
  endtask

  task automatic setAlloc(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BL-1:0] m);
    i_alloc_en = 1; i_alloc_addr = a; i_alloc_data = d; i_alloc_byte_mask = m;
    i_alloc_tag = RW'(mTail);
  endtask

  task automatic setLookup(input logic [AW-1:0] a, input logic [BL-1:0] m, input int snap);
    i_lookup_en = 1; i_lookup_addr = a; i_lookup_byte_mask = m; lSnap = snap;
  endtask

  // Computes expected results from the pre-cycle model, advances the model, clocks once.
  task automatic step();
    int y;
    logic isFull, commitOk;
    i_lookup_sq_tail = lSnap[IW:0];
    y = -1;
    if (i_lookup_en)
      for (int s = lSnap - 1; s >= mHead; s--)
        if (y < 0 && (mAddr[s & 255] >> 2) == (i_lookup_addr >> 2) &&
            (mMask[s & 255] & i_lookup_byte_mask) != 0)
          y = s;
    expValid = i_lookup_en && !i_flush;
    expHit   = expValid && (y >= 0) && ((mMask[(y < 0 ? 0 : y) & 255] & i_lookup_byte_mask) == i_lookup_byte_mask);
    expConf  = expValid && (y >= 0) && !expHit;
    expData  = expHit ? mData[y & 255] : '0;
    isFull   = (mTail - mHead) == DEPTH;
    commitOk = i_rob_retire_en && (mCommit != mTail) && (mTag[mCommit & 255] == i_rob_retire_tag);
    expAck   = commitOk;
    if (i_drain_ack && mHead != mCommit) mHead++;
    if (commitOk) mCommit++;
    if (i_flush) mTail = mCommit;
    else if (i_alloc_en && !isFull) begin
      mAddr[mTail & 255] = i_alloc_addr; mData[mTail & 255] = i_alloc_data;
      mMask[mTail & 255] = i_alloc_byte_mask; mTag[mTail & 255] = i_alloc_tag;
      mTail++;
    end
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    n_rst = 0;
    mHead = 0; mCommit = 0; mTail = 0;
    clearInputs();
    @(posedge clk); #3;
    n_rst = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    logic [IW:0] t;
    n_rst = 0;
    mHead = 0; mCommit = 0; mTail = 0;
    clearInputs();
    #1;
    checks++; if (o_full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %0b want 0", o_full); end
    checks++; if (o_tail !== 4'h0) begin errors++; $display("[TB] FAIL reset_tail got %0h want 0", o_tail); end
    checks++; if (o_drain_en !== 1'b0 || o_drain_addr !== '0 || o_drain_data !== '0 || o_drain_byte_mask !== '0) begin
      errors++; $display("[TB] FAIL reset_drain got en=%0b addr=%0h want all 0", o_drain_en, o_drain_addr); end
    checks++; if (o_lookup_valid !== 1'b0 || o_lookup_hit !== 1'b0 || o_lookup_conflict !== 1'b0 || o_lookup_data !== '0) begin
      errors++; $display("[TB] FAIL reset_lookup got v=%0b h=%0b c=%0b want 0", o_lookup_valid, o_lookup_hit, o_lookup_conflict); end
    checks++; if (o_rob_retire_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack got %0b want 0", o_rob_retire_ack); end
    doReset();
    t = o_tail;
    checks++; if (t !== 4'h0) begin errors++; $display("[TB] FAIL reset_release_tail got %0h want 0", t); end
  endtask

  task automatic test_full();
    doReset();
    for (int k = 0; k < 9; k++) begin
      clearInputs();
      setAlloc(32'h1000 + 32'(k * 4), 32'($urandom), 4'hF);
      step();
      if (k == 6) begin
        checks++; if (o_full !== 1'b0) begin errors++; $display("[TB] FAIL full_after7 got %0b want 0", o_full); end
      end
      if (k == 7) begin
        checks++; if (o_full !== 1'b1) begin errors++; $display("[TB] FAIL full_after8 got %0b want 1", o_full); end
      end
    end
    checks++; if (o_tail !== 4'h8) begin errors++; $display("[TB] FAIL full_drop_tail got %0h want 8", o_tail); end
    checks++; if (o_full !== 1'b1) begin errors++; $display("[TB] FAIL full_stays got %0b want 1", o_full); end
  endtask

  task automatic test_forward_hit();
    doReset();
    clearInputs(); setAlloc(32'h100, 32'hDEADBEEF, 4'hF); step();
    clearInputs(); setLookup(32'h102, 4'h4, mTail); step();
    checks++; if (o_lookup_valid !== 1'b1 || o_lookup_hit !== 1'b1 || o_lookup_conflict !== 1'b0) begin
      errors++; $display("[TB] FAIL fwd_hit got v=%0b h=%0b c=%0b want 1 1 0", o_lookup_valid, o_lookup_hit, o_lookup_conflict); end
    checks++; if (o_lookup_data !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL fwd_data got %0h want deadbeef", o_lookup_data); end
    clearInputs(); step();
    checks++; if (o_lookup_valid !== 1'b0) begin errors++; $display("[TB] FAIL fwd_single_result got %0b want 0", o_lookup_valid); end
    // in-flight lookup and ack are dropped by an asynchronous reset
    clearInputs(); setLookup(32'h100, 4'h1, mTail); step();
    n_rst = 0; #1;
    checks++; if (o_lookup_valid !== 1'b0 || o_tail !== 4'h0) begin
      errors++; $display("[TB] FAIL midreset got v=%0b tail=%0h want 0 0", o_lookup_valid, o_tail); end
  endtask

  task automatic test_conflict();
    doReset();
    clearInputs(); setAlloc(32'h200, 32'h11223344, 4'hF); step();
    clearInputs(); setAlloc(32'h200, 32'h000000AA, 4'h1); step();
    clearInputs(); setLookup(32'h200, 4'h3, mTail); step();
    checks++; if (o_lookup_conflict !== 1'b1 || o_lookup_hit !== 1'b0) begin
      errors++; $display("[TB] FAIL conflict got h=%0b c=%0b want 0 1", o_lookup_hit, o_lookup_conflict); end
    clearInputs(); setLookup(32'h201, 4'h1, mTail); step();
    checks++; if (o_lookup_hit !== 1'b1 || o_lookup_data !== 32'h000000AA) begin
      errors++; $display("[TB] FAIL youngest got h=%0b d=%0h want 1 aa", o_lookup_hit, o_lookup_data); end
    clearInputs(); setLookup(32'h200, 4'hC, mTail); step();
    checks++; if (o_lookup_hit !== 1'b1 || o_lookup_data !== 32'h11223344) begin
      errors++; $display("[TB] FAIL older_lanes got h=%0b d=%0h want 1 11223344", o_lookup_hit, o_lookup_data); end
  endtask

  task automatic test_old_snapshot();
    int snap;
    doReset();
    snap = mTail;
    clearInputs(); setAlloc(32'h400, 32'hCAFEF00D, 4'hF); step();
    clearInputs(); setLookup(32'h400, 4'hF, snap); step();
    checks++; if (o_lookup_valid !== 1'b1 || o_lookup_hit !== 1'b0 || o_lookup_conflict !== 1'b0) begin
      errors++; $display("[TB] FAIL old_snapshot got v=%0b h=%0b c=%0b want 1 0 0", o_lookup_valid, o_lookup_hit, o_lookup_conflict); end
  endtask

  task automatic test_flush_drain();
    doReset();
    for (int k = 0; k < 4; k++) begin
      clearInputs(); setAlloc(32'h500 + 32'(k * 4), 32'h5000 + 32'(k), 4'hF); step();
    end
    for (int k = 0; k < 2; k++) begin
      clearInputs(); i_rob_retire_en = 1; i_rob_retire_tag = RW'(k); step();
      checks++; if (o_rob_retire_ack !== 1'b1) begin errors++; $display("[TB] FAIL commit_ack%0d got %0b want 1", k, o_rob_retire_ack); end
    end
    clearInputs(); i_flush = 1; i_alloc_en = 1; setLookup(32'h500, 4'hF, mTail); step();
    checks++; if (o_tail !== 4'h2) begin errors++; $display("[TB] FAIL flush_tail got %0h want 2", o_tail); end
    checks++; if (o_lookup_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_lookup got %0b want 0", o_lookup_valid); end
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_drain_en !== 1'b1 || o_drain_addr !== 32'h500 + 32'(k * 4) || o_drain_data !== 32'h5000 + 32'(k)) begin
        errors++; $display("[TB] FAIL drain%0d got en=%0b addr=%0h want 1 %0h", k, o_drain_en, o_drain_addr, 32'h500 + k * 4); end
      clearInputs(); i_drain_ack = 1; step();
    end
    checks++; if (o_drain_en !== 1'b0 || o_full !== 1'b0) begin
      errors++; $display("[TB] FAIL drain_empty got en=%0b full=%0b want 0 0", o_drain_en, o_full); end
  endtask

  task automatic test_wrong_tag();
    doReset();
    clearInputs(); setAlloc(32'h600, 32'h1, 4'hF); step();
    clearInputs(); i_rob_retire_en = 1; i_rob_retire_tag = 5'd7; step();
    checks++; if (o_rob_retire_ack !== 1'b0 || o_drain_en !== 1'b0) begin
      errors++; $display("[TB] FAIL wrong_tag got ack=%0b drain=%0b want 0 0", o_rob_retire_ack, o_drain_en); end
    clearInputs(); i_rob_retire_en = 1; i_rob_retire_tag = 5'd0; step();
    checks++; if (o_rob_retire_ack !== 1'b1 || o_drain_en !== 1'b1) begin
      errors++; $display("[TB] FAIL right_tag got ack=%0b drain=%0b want 1 1", o_rob_retire_ack, o_drain_en); end
  endtask

  task automatic test_random_wrap();
    logic [IW:0] expTail;
    doReset();
    for (int c = 0; c < 400; c++) begin
      clearInputs();
      if ($urandom_range(0, 15) == 0) i_flush = 1;
      if ($urandom_range(0, 2) != 0)
        setAlloc(32'h300 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)), 32'($urandom), 4'($urandom_range(1, 15)));
      if ($urandom_range(0, 1) == 1) begin
        i_rob_retire_en = 1;
        i_rob_retire_tag = ($urandom_range(0, 3) != 0) ? mTag[mCommit & 255] : RW'($urandom);
      end
      i_drain_ack = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 9) < 7)
        setLookup(32'h300 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
                  mHead + $urandom_range(0, mTail - mHead));
      step();
      expTail = mTail[IW:0];
      checks++; if (o_lookup_valid !== expValid || o_lookup_hit !== expHit || o_lookup_conflict !== expConf || o_lookup_data !== expData) begin
        errors++; $display("[TB] FAIL rand_lookup c=%0d got v=%0b h=%0b x=%0b d=%0h want %0b %0b %0b %0h",
                           c, o_lookup_valid, o_lookup_hit, o_lookup_conflict, o_lookup_data, expValid, expHit, expConf, expData); end
      checks++; if (o_rob_retire_ack !== expAck) begin errors++; $display("[TB] FAIL rand_ack c=%0d got %0b want %0b", c, o_rob_retire_ack, expAck); end
      checks++; if (o_tail !== expTail || o_full !== ((mTail - mHead) == DEPTH)) begin
        errors++; $display("[TB] FAIL rand_ptr c=%0d got tail=%0h full=%0b want %0h %0b", c, o_tail, o_full, expTail, (mTail - mHead) == DEPTH); end
      checks++; if (o_drain_en !== (mHead != mCommit)) begin
        errors++; $display("[TB] FAIL rand_drain_en c=%0d got %0b want %0b", c, o_drain_en, mHead != mCommit); end
      if (mHead != mCommit) begin
        checks++; if (o_drain_addr !== mAddr[mHead & 255] || o_drain_data !== mData[mHead & 255] || o_drain_byte_mask !== mMask[mHead & 255]) begin
          errors++; $display("[TB] FAIL rand_drain c=%0d got addr=%0h data=%0h want %0h %0h",
                             c, o_drain_addr, o_drain_data, mAddr[mHead & 255], mData[mHead & 255]); end
      end
    end
    checks++; if (mHead < 20) begin errors++; $display("[TB] FAIL rand_wrap drained=%0d want >=20", mHead); end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    mHead = 0; mCommit = 0; mTail = 0;
    clearInputs();
    n_rst = 1;
    test_reset();
    test_full();
    test_forward_hit();
    test_conflict();
    test_old_snapshot();
    test_flush_drain();
    test_wrong_tag();
    test_random_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
